// File: rtl/mic_level_meter.sv
// mic_level_meter: mean-absolute level and peak-hold meter for signed PCM
// samples from the I2S microphone receiver.
// Pipeline: stage 1 registers the saturated magnitude, stage 2 accumulates
// the window, and the output stage publishes level/peak and runs the
// hold-then-decay peak ballistics, so a window's result appears two edges
// after its final sample is captured.
module mic_level_meter #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int WINDOW_LOG2  = 10,
  parameter int PEAK_HOLD    = 48,
  parameter int DECAY_SHIFT  = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  input  logic                    clear_in,
  output logic [SAMPLE_WIDTH-1:0] level_out,
  output logic                    level_valid_out,
  output logic [SAMPLE_WIDTH-1:0] peak_out,
  output logic                    clip_out
);

  // Magnitudes never exceed 2^(SAMPLE_WIDTH-1)-1, so they fit in one bit less.
  localparam int MW = SAMPLE_WIDTH - 1;
  // A full window of maximal magnitudes fits without overflow.
  localparam int AW = MW + WINDOW_LOG2;
  localparam int HW = (PEAK_HOLD > 0) ? $clog2(PEAK_HOLD + 1) : 1;

  localparam logic [MW-1:0]           MAG_MAX   = {MW{1'b1}};
  localparam logic [SAMPLE_WIDTH-1:0] MOST_NEG  = {1'b1, {MW{1'b0}}};
  localparam logic [WINDOW_LOG2-1:0]  CNT_LAST  = {WINDOW_LOG2{1'b1}};
  localparam logic [HW-1:0]           HOLD_INIT = HW'(PEAK_HOLD);

  // Absolute value with the most-negative code saturated to full scale.
  function automatic logic [MW-1:0] sat_abs(input logic [SAMPLE_WIDTH-1:0] s);
    logic [MW-1:0] r;
    if (s == MOST_NEG) begin
      r = MAG_MAX;
    end else if (s[SAMPLE_WIDTH-1]) begin
      r = ~s[MW-1:0] + MW'(1'b1);
    end else begin
      r = s[MW-1:0];
    end
    return r;
  endfunction

  // One decay step: drop by peak >> DECAY_SHIFT, but always by at least 1.
  function automatic logic [MW-1:0] decay_step(input logic [MW-1:0] p);
    logic [MW-1:0] d;
    d = ((p >> DECAY_SHIFT) == '0) ? MW'(1'b1) : (p >> DECAY_SHIFT);
    return p - d;
  endfunction

  logic [MW-1:0]          mag_s;
  logic [AW-1:0]          sum_s;
  logic [MW-1:0]          wmax_s;

  logic                   s1_valid_q, s1_valid_d;
  logic [MW-1:0]          mag_q, mag_d;
  logic                   clip_q, clip_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [MW-1:0]          win_max_q, win_max_d;
  logic                   done_q, done_d;
  logic [MW-1:0]          fin_level_q, fin_level_d;
  logic [MW-1:0]          fin_max_q, fin_max_d;
  logic [MW-1:0]          level_q, level_d;
  logic                   level_valid_q, level_valid_d;
  logic [MW-1:0]          peak_q, peak_d;
  logic [HW-1:0]          hold_q, hold_d;

  // Stage 1: capture saturated magnitude and raise the sticky clip flag.
  always_comb begin
    mag_s      = sat_abs(sample_in);
    s1_valid_d = sample_valid_in;
    mag_d      = mag_q;
    clip_d     = clip_q;
    if (clear_in) begin
      s1_valid_d = 1'b0;
      clip_d     = 1'b0;
    end else if (sample_valid_in) begin
      mag_d  = mag_s;
      clip_d = clip_q | (mag_s == MAG_MAX);
    end else begin
      mag_d = mag_q;
    end
  end

  // Stage 2: accumulate the window; on its last sample latch the totals.
  always_comb begin
    sum_s       = acc_q + AW'(mag_q);
    wmax_s      = (mag_q > win_max_q) ? mag_q : win_max_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    win_max_d   = win_max_q;
    done_d      = 1'b0;
    fin_level_d = fin_level_q;
    fin_max_d   = fin_max_q;
    if (clear_in) begin
      acc_d     = '0;
      cnt_d     = '0;
      win_max_d = '0;
    end else if (s1_valid_q) begin
      if (cnt_q == CNT_LAST) begin
        done_d      = 1'b1;
        fin_level_d = sum_s[AW-1:WINDOW_LOG2];
        fin_max_d   = wmax_s;
        acc_d       = '0;
        cnt_d       = '0;
        win_max_d   = '0;
      end else begin
        acc_d     = sum_s;
        cnt_d     = cnt_q + WINDOW_LOG2'(1'b1);
        win_max_d = wmax_s;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Output stage: publish the level and run peak hold-then-decay ballistics.
  always_comb begin
    level_d       = level_q;
    level_valid_d = 1'b0;
    peak_d        = peak_q;
    hold_d        = hold_q;
    if (clear_in) begin
      level_d = '0;
      peak_d  = '0;
      hold_d  = '0;
    end else if (done_q) begin
      level_valid_d = 1'b1;
      level_d       = fin_level_q;
      if (fin_max_q >= peak_q) begin
        peak_d = fin_max_q;
        hold_d = HOLD_INIT;
      end else if (hold_q != '0) begin
        hold_d = hold_q - HW'(1'b1);
      end else if (peak_q != '0) begin
        peak_d = decay_step(peak_q);
      end else begin
        peak_d = peak_q;
      end
    end else begin
      level_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q    <= 1'b0;
      mag_q         <= '0;
      clip_q        <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      win_max_q     <= '0;
      done_q        <= 1'b0;
      fin_level_q   <= '0;
      fin_max_q     <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      peak_q        <= '0;
      hold_q        <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      mag_q         <= mag_d;
      clip_q        <= clip_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      win_max_q     <= win_max_d;
      done_q        <= done_d;
      fin_level_q   <= fin_level_d;
      fin_max_q     <= fin_max_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      peak_q        <= peak_d;
      hold_q        <= hold_d;
    end
  end

  assign level_out       = {1'b0, level_q};
  assign peak_out        = {1'b0, peak_q};
  assign level_valid_out = level_valid_q;
  assign clip_out        = clip_q;

endmodule

// File: tb/tb_mic_level_meter.sv
// Scoreboard bench for mic_level_meter: the driver feeds a window-level
// reference model that queues expected (level, peak, pulse edge) records;
// an independent monitor pops them whenever the DUT pulses level_valid_out.
module tb_mic_level_meter;
  localparam int SW     = 24;
  localparam int WL     = 2;
  localparam int PH     = 2;
  localparam int DS     = 1;
  localparam int WIN    = 1 << WL;
  localparam int MAGMAX = (1 << (SW - 1)) - 1;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [SW-1:0] sample_in;
  logic          sample_valid_in;
  logic          clear_in;
  logic [SW-1:0] level_out;
  logic          level_valid_out;
  logic [SW-1:0] peak_out;
  logic          clip_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int level;
    int peak;
    int edge_no;
  } exp_t;
  exp_t expq[$];

  // Reference model state: running window and peak ballistics.
  int m_sum, m_max, m_n, m_peak, m_hold;
  int clip_edge = -1;

  mic_level_meter #(
    .SAMPLE_WIDTH(SW),
    .WINDOW_LOG2 (WL),
    .PEAK_HOLD   (PH),
    .DECAY_SHIFT (DS)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .sample_in      (sample_in),
    .sample_valid_in(sample_valid_in),
    .clear_in       (clear_in),
    .level_out      (level_out),
    .level_valid_out(level_valid_out),
    .peak_out       (peak_out),
    .clip_out       (clip_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void model_clear();
    m_sum     = 0;
    m_max     = 0;
    m_n       = 0;
    m_peak    = 0;
    m_hold    = 0;
    clip_edge = -1;
  endfunction

  // Accept one sample captured at clock edge e.
  function automatic void model_accept(int s, int e);
    int   mag;
    int   d;
    exp_t x;
    mag = (s < 0) ? -s : s;
    if (mag > MAGMAX) mag = MAGMAX;
    if (mag == MAGMAX && clip_edge < 0) clip_edge = e;
    m_sum += mag;
    if (mag > m_max) m_max = mag;
    m_n++;
    if (m_n == WIN) begin
      if (m_max >= m_peak) begin
        m_peak = m_max;
        m_hold = PH;
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (m_peak > 0) begin
        d = m_peak >> DS;
        if (d < 1) d = 1;
        m_peak -= d;
      end
      x.level   = m_sum / WIN;
      x.peak    = m_peak;
      x.edge_no = e + 2;
      expq.push_back(x);
      m_sum = 0;
      m_max = 0;
      m_n   = 0;
    end
  endfunction

  // Drive one cycle of inputs at the falling edge and update the model.
  task automatic drive(input int s, input logic v, input logic c);
    @(negedge clk_in);
    sample_in       = s[SW-1:0];
    sample_valid_in = v;
    clear_in        = c;
    if (c) model_clear();
    else if (v) model_accept(s, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1'b0, 1'b0);
  endtask

  // Monitor: count edges, then check pulses against the scoreboard and clip.
  always @(posedge clk_in) begin
    exp_t x;
    int   exp_clip;
    cyc = cyc + 1;
    #1;
    if (rst_n_in) begin
      while (expq.size() > 0 && expq[0].edge_no < cyc) begin
        check("pulse_missing_edge", cyc, expq[0].edge_no);
        x = expq.pop_front();
      end
      if (level_valid_out) begin
        if (expq.size() == 0) begin
          check("unexpected_pulse_pending", expq.size(), 1);
        end else begin
          x = expq.pop_front();
          check("pulse_edge", cyc, x.edge_no);
          check("level", int'(level_out), x.level);
          check("peak", int'(peak_out), x.peak);
        end
      end
      exp_clip = (clip_edge >= 0 && cyc >= clip_edge) ? 1 : 0;
      check("clip", int'(clip_out), exp_clip);
    end
  end

  initial begin
    int s;
    int samp1[4];
    samp1 = '{100, -200, 300, -400};
    rst_n_in        = 1'b0;
    sample_in       = '0;
    sample_valid_in = 1'b0;
    clear_in        = 1'b0;
    model_clear();
    #2;
    check("reset_level", int'(level_out), 0);
    check("reset_peak", int'(peak_out), 0);
    check("reset_valid", int'(level_valid_out), 0);
    check("reset_clip", int'(clip_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // Basic window.
    for (int i = 0; i < 4; i++) drive(samp1[i], 1'b1, 1'b0);
    idle(4);
    check("s1_level", int'(level_out), 250);
    check("s1_peak", int'(peak_out), 400);

    // Clip and saturation, sticky across further windows.
    drive(0, 1'b0, 1'b1);
    drive(-8388608, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b0);
    idle(3);
    check("s2_level", int'(level_out), 2097151);
    check("s2_peak", int'(peak_out), 8388607);
    for (int i = 0; i < 12; i++) drive(0, 1'b1, 1'b0);
    idle(3);
    check("s2_clip_sticky", int'(clip_out), 1);
    drive(0, 1'b0, 1'b1);
    idle(1);
    check("s2_clear_clip", int'(clip_out), 0);
    check("s2_clear_level", int'(level_out), 0);
    check("s2_clear_peak", int'(peak_out), 0);

    // Hold then decay.
    for (int i = 0; i < 4; i++) drive(400, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(0, 1'b1, 1'b0);
    idle(3);
    check("s3_peak_final", int'(peak_out), 50);
    check("s3_level_final", int'(level_out), 0);

    // Clear mid-window drops the simultaneous sample.
    drive(0, 1'b0, 1'b1);
    drive(1000, 1'b1, 1'b0);
    drive(1000, 1'b1, 1'b0);
    drive(5000, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) drive(8, 1'b1, 1'b0);
    idle(3);
    check("s4_level", int'(level_out), 8);
    check("s4_peak", int'(peak_out), 8);

    // Async reset mid-window (clip set first so all outputs are non-zero).
    drive(8388607, 1'b1, 1'b0);
    drive(12, 1'b1, 1'b0);
    drive(12, 1'b1, 1'b0);
    @(posedge clk_in);
    #3;
    rst_n_in        = 1'b0;
    sample_valid_in = 1'b0;
    model_clear();
    #1;
    check("s5_rst_level", int'(level_out), 0);
    check("s5_rst_peak", int'(peak_out), 0);
    check("s5_rst_clip", int'(clip_out), 0);
    check("s5_rst_valid", int'(level_valid_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < 4; i++) drive(12, 1'b1, 1'b0);
    idle(3);
    check("s5_level", int'(level_out), 12);

    // Gapped input.
    drive(0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(samp1[i], 1'b1, 1'b0);
      idle(2);
    end
    idle(2);
    check("s6_level", int'(level_out), 250);
    check("s6_peak", int'(peak_out), 400);

    // Randomized phases: small, large (with extremes), then mostly silence.
    for (int b = 0; b < 9; b++) begin
      for (int i = 0; i < 60; i++) begin
        case (b % 3)
          0: s = int'($urandom_range(0, 2000)) - 1000;
          1: begin
            case ($urandom_range(0, 7))
              0:       s = -8388608;
              1:       s = 8388607;
              default: s = int'($urandom_range(0, 16777215)) - 8388608;
            endcase
          end
          default: s = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 300)) : 0;
        endcase
        drive(s, 1'($urandom_range(0, 1)), 1'b0);
      end
      if (b % 3 == 2) begin
        idle(4);
        drive(0, 1'b0, 1'b1);
      end
    end

    idle(6);
    check("scoreboard_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
